// File: rtl/mem_copy_initiator.sv
// Word-by-word memory copy engine: read, wait for data, write, repeat for len words.
// Optional running checksum of copied words is enabled with `define MEM_COPY_CHECKSUM_EN.
module mem_copy_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       len,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  input  logic [15:0]       sizes,
  output logic              busy,
  output logic              done,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [31:0]       bytes_moved
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [15:0]       len_q;
  logic [15:0]       idx;
  logic [15:0]       next_idx;

  assign next_idx = idx + 16'd1;
  assign busy     = (state != IDLE);

  // Strobes are registered on entry to their state so ren is high exactly in
  // READ and wen exactly in WRITE; done trails the DONE state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx         <= '0;
      raddr       <= '0;
      ren         <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      wen         <= 1'b0;
      done        <= 1'b0;
      bytes_moved <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q       <= src_addr;
            dst_q       <= dst_addr;
            len_q       <= len;
            idx         <= '0;
            bytes_moved <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum    <= '0;
`endif
            if (len == 16'd0) begin
              state <= DONE;
            end else begin
              state <= READ;
              ren   <= 1'b1;
              raddr <= src_addr;
            end
          end
        end
        READ: begin
          ren   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // wdata doubles as the captured-word register and holds between writes
          wdata <= rdata;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum <= checksum + rdata;
`endif
          wen   <= 1'b1;
          waddr <= dst_q + ADDR_W'(idx);
          state <= WRITE;
        end
        WRITE: begin
          wen         <= 1'b0;
          bytes_moved <= bytes_moved + {16'd0, sizes};
          idx         <= next_idx;
          if (next_idx == len_q) begin
            state <= DONE;
          end else begin
            state <= READ;
            ren   <= 1'b1;
            raddr <= src_q + ADDR_W'(next_idx);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator: behavioural memory, edge counter and
// immediate-assertion checks on copies, timing, wrap, busy-start and reset abort.
module tb_mem_copy_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [15:0] raddr;
  logic        ren;
  logic [31:0] rdata = '0;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [15:0] sizes = 16'd4;
  logic        busy;
  logic        done;
  logic [31:0] bytes_moved;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_copy_initiator #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .raddr(raddr), .ren(ren), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wen(wen),
    .sizes(sizes), .busy(busy), .done(done),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bytes_moved(bytes_moved)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int overlap = 0;
  int done_cnt = 0;
  int start_edge = 0;
  logic [15:0] raddr_q[$];
  logic [31:0] mem [0:65535];

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (ren) rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
  end

  always @(negedge clk) begin
    if (ren) begin
      ren_cnt = ren_cnt + 1;
      raddr_q.push_back(raddr);
    end
    if (wen) wen_cnt = wen_cnt + 1;
    if (ren && wen) overlap = overlap + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = n;
    start = 1'b1;
    start_edge = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns cycles from the start-sampling edge to the edge preceding the done cycle
  task automatic wait_done(input int max, output int lat);
    lat = -1;
    if (done) lat = edge_cnt - start_edge;
    for (int i = 0; i < max && lat < 0; i++) begin
      @(negedge clk);
      if (done) lat = edge_cnt - start_edge;
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  int r0, w0, d0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i);

    // reset state
    do_reset();
    check("rst_ren", {31'd0, ren}, 32'd0);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_raddr", {16'd0, raddr}, 32'd0);
    check("rst_waddr", {16'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_bytes", bytes_moved, 32'd0);

    // basic copy of 4 words
    sizes = 16'd4;
    r0 = ren_cnt; w0 = wen_cnt;
    go(16'd0, 16'd100, 16'd4);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(40, lat);
    check("copy4_latency", 32'(lat), 32'd13);
    check("copy4_bytes", bytes_moved, 32'd16);
`ifdef MEM_COPY_CHECKSUM_EN
    check("copy4_checksum", checksum, 32'd6);
`endif
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("copy4_mem100", mem[100], 32'd0);
    check("copy4_mem101", mem[101], 32'd1);
    check("copy4_mem102", mem[102], 32'd2);
    check("copy4_mem103", mem[103], 32'd3);
    check("copy4_rens", 32'(ren_cnt - r0), 32'd4);
    check("copy4_wens", 32'(wen_cnt - w0), 32'd4);
    check("copy4_waddr_hold", {16'd0, waddr}, 32'd103);
    check("copy4_wdata_hold", wdata, 32'd3);

    // zero-length transfer
    r0 = ren_cnt; w0 = wen_cnt;
    go(16'd7, 16'd9, 16'd0);
    wait_done(10, lat);
    check("len0_latency", 32'(lat), 32'd1);
    check("len0_bytes", bytes_moved, 32'd0);
    repeat (3) @(negedge clk);
    check("len0_rens", 32'(ren_cnt - r0), 32'd0);
    check("len0_wens", 32'(wen_cnt - w0), 32'd0);

    // source address wrap, 2 bytes per access
    sizes = 16'd2;
    raddr_q.delete();
    go(16'hFFFE, 16'h0200, 16'd4);
    wait_done(40, lat);
    check("wrap_latency", 32'(lat), 32'd13);
    check("wrap_bytes", bytes_moved, 32'd8);
    @(negedge clk);
    check("wrap_nreads", 32'(raddr_q.size()), 32'd4);
    if (raddr_q.size() == 4) begin
      check("wrap_raddr0", {16'd0, raddr_q[0]}, 32'h0000FFFE);
      check("wrap_raddr1", {16'd0, raddr_q[1]}, 32'h0000FFFF);
      check("wrap_raddr2", {16'd0, raddr_q[2]}, 32'h00000000);
      check("wrap_raddr3", {16'd0, raddr_q[3]}, 32'h00000001);
    end
    check("wrap_mem200", mem[16'h0200], 32'h0000FFFE);
    check("wrap_mem203", mem[16'h0203], 32'h00000001);

    // start pulses while busy are ignored
    sizes = 16'd4;
    d0 = done_cnt; w0 = wen_cnt;
    go(16'd0, 16'd300, 16'd2);
    for (int k = 0; k < 3; k++) begin
      src_addr = 16'd50; dst_addr = 16'd400; len = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(40, lat);
    check("busy_latency", 32'(lat), 32'd7);
    repeat (20) @(negedge clk);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_wens", 32'(wen_cnt - w0), 32'd2);
    check("busy_bytes", bytes_moved, 32'd8);
    check("busy_mem300", mem[300], 32'd0);
    check("busy_mem301", mem[301], 32'd1);
    check("busy_mem400", mem[400], 32'd400);

    // reset during WAIT of word index 2
    w0 = wen_cnt;
    go(16'd0, 16'd500, 16'd8);
    repeat (7) @(negedge clk);
    check("abort_wens_before", 32'(wen_cnt - w0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ren", {31'd0, ren}, 32'd0);
    check("abort_wen", {31'd0, wen}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_raddr", {16'd0, raddr}, 32'd0);
    check("abort_waddr", {16'd0, waddr}, 32'd0);
    check("abort_wdata", wdata, 32'd0);
    check("abort_bytes", bytes_moved, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_wens_after", 32'(wen_cnt - w0), 32'd2);
    check("abort_mem502", mem[502], 32'd502);
    check("abort_mem501", mem[501], 32'd1);

    // overlapping ranges, ascending order propagates word 0
    go(16'd0, 16'd1, 16'd3);
    wait_done(40, lat);
    check("ovl_latency", 32'(lat), 32'd10);
    @(negedge clk);
    check("ovl_mem0", mem[0], 32'd0);
    check("ovl_mem1", mem[1], 32'd0);
    check("ovl_mem2", mem[2], 32'd0);
    check("ovl_mem3", mem[3], 32'd0);
    check("ren_wen_exclusive", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
